// File: rtl/tl_ul_host_arbiter.sv
// TileLink-UL host port arbiter: fetch and LSU share one channel A/D pair.
// One transaction in flight; ties alternate; channel D wait is bounded by
// TIMEOUT and an expired wait returns an error response to the owner.
module tl_ul_host_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,
  // load/store requester
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  input  logic [3:0]        lsu_mask_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o,
  // channel A
  output logic              a_valid_o,
  input  logic              a_ready_i,
  output logic [2:0]        a_opcode_o,
  output logic [1:0]        a_size_o,
  output logic [3:0]        a_mask_o,
  output logic [ADDR_W-1:0] a_address_o,
  output logic [31:0]       a_data_o,
  output logic              a_source_o,
  // channel D
  input  logic              d_valid_i,
  output logic              d_ready_o,
  input  logic [2:0]        d_opcode_i,
  input  logic              d_source_i,
  input  logic [31:0]       d_data_i,
  input  logic              d_error_i
);

  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;
  localparam logic [7:0] TMO_CNT     = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT} state_e;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [3:0]        mask;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              src;   // 0 = fetch, 1 = LSU
  } a_req_t;

  state_e      state_q, state_d;
  a_req_t      req_sel, req_q;
  logic        live_q;       // low only in the first cycle after reset
  logic        last_lsu_q;   // last grant went to the LSU
  logic [7:0]  cnt_q, cnt_inc;
  logic        grant_if, grant_lsu;
  logic        d_match, tmo_hit;
  logic [31:0] resp_data;
  logic        resp_err;

  // Arbitration: only in IDLE; a tie goes to whoever was not granted last
  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE && live_q) begin
      if (if_req_i && lsu_req_i) begin
        grant_if  = last_lsu_q;
        grant_lsu = ~last_lsu_q;
      end else begin
        grant_if  = if_req_i;
        grant_lsu = lsu_req_i;
      end
    end
  end

  assign if_gnt_o  = grant_if;
  assign lsu_gnt_o = grant_lsu;

  // Encode the winning request into a channel A beat
  always_comb begin
    req_sel        = '0;
    req_sel.opcode = OP_GET;
    req_sel.mask   = 4'hF;
    req_sel.addr   = if_addr_i;
    if (grant_lsu) begin
      req_sel.src  = 1'b1;
      req_sel.addr = lsu_addr_i;
      if (lsu_we_i) begin
        req_sel.data = lsu_wdata_i;
        if (lsu_mask_i == 4'hF) begin
          req_sel.opcode = OP_PUT_FULL;
        end else begin
          req_sel.opcode = OP_PUT_PART;
          req_sel.mask   = lsu_mask_i;
        end
      end
    end
  end

  // A matching beat beats the terminal count when both land together
  assign d_match = (state_q == D_WAIT) && d_ready_o && d_valid_i && (d_source_i == req_q.src);
  assign cnt_inc = cnt_q + 8'd1;
  assign tmo_hit = (state_q == D_WAIT) && !d_match && (cnt_inc == TMO_CNT);

  assign resp_data = (d_match && d_opcode_i == OP_ACK_DATA) ? d_data_i : 32'h0;
  assign resp_err  = d_match ? d_error_i : 1'b1;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_if || grant_lsu) state_d = A_SEND;
      A_SEND:  if (a_valid_o && a_ready_i) state_d = D_WAIT;
      D_WAIT:  if (d_match || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration history and the latched request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      live_q     <= 1'b0;
      last_lsu_q <= 1'b0;
      req_q      <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (grant_if || grant_lsu) begin
        req_q      <= req_sel;
        last_lsu_q <= grant_lsu;
      end
    end
  end

  // Channel D wait counter: restarts at the A handshake, frozen by a match
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == A_SEND && a_ready_i) begin
      cnt_q <= '0;
    end else if (state_q == D_WAIT && !d_match) begin
      cnt_q <= cnt_inc;
    end
  end

  // Registered channel A/D handshake outputs and A fields
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_valid_o   <= 1'b0;
      d_ready_o   <= 1'b0;
      a_opcode_o  <= '0;
      a_size_o    <= '0;
      a_mask_o    <= '0;
      a_address_o <= '0;
      a_data_o    <= '0;
      a_source_o  <= 1'b0;
    end else begin
      a_valid_o <= (state_d == A_SEND);
      d_ready_o <= (state_d != A_SEND);
      if (grant_if || grant_lsu) begin
        a_opcode_o  <= req_sel.opcode;
        a_size_o    <= 2'b10;
        a_mask_o    <= req_sel.mask;
        a_address_o <= req_sel.addr;
        a_data_o    <= req_sel.data;
        a_source_o  <= req_sel.src;
      end
    end
  end

  // Response pulses, routed only to the owning requester
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_rvalid_o  <= 1'b0;
      if_rdata_o   <= '0;
      if_err_o     <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= '0;
      lsu_err_o    <= 1'b0;
    end else begin
      if_rvalid_o  <= 1'b0;
      if_rdata_o   <= '0;
      if_err_o     <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= '0;
      lsu_err_o    <= 1'b0;
      if (d_match || tmo_hit) begin
        if (req_q.src) begin
          lsu_rvalid_o <= 1'b1;
          lsu_rdata_o  <= resp_data;
          lsu_err_o    <= resp_err;
        end else begin
          if_rvalid_o <= 1'b1;
          if_rdata_o  <= resp_data;
          if_err_o    <= resp_err;
        end
      end
    end
  end

endmodule
